computie_bus_trace_controller: RTL and testbench

//  Sequences computie bus tracing: captures completed bus cycles into a circular trace RAM,

---
 rtl/computie_bus_trace_if.sv | 38 +++
 rtl/computie_bus_trace_controller.sv | 147 ++++++++++++++
 tb/tb_computie_bus_trace_controller.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/computie_bus_trace_if.sv
// rtl/computie_bus_trace_if.sv - capture tap, trigger and dumper signals of the bus trace controller
interface computie_bus_trace_if #(
    parameter int BITWIDTH = 32,
    parameter int MODWIDTH = 1,
    parameter int DEPTH    = 512
);
    localparam int IW = $clog2(DEPTH) + 1;
    localparam int RW = 2 * BITWIDTH + MODWIDTH;

    logic                capture_valid;
    logic [RW-1:0]       capture_in;
    logic                arm;
    logic                force_trigger;
    logic [IW-1:0]       post_count;
    logic [BITWIDTH-1:0] trig_addr;
    logic [BITWIDTH-1:0] trig_mask;
    logic                armed;
    logic                triggered;
    logic                done;
    logic                dump_start;
    logic                dump_end;
    logic                record_in_enable;
    logic [IW-1:0]       record_in_request;
    logic [IW-1:0]       record_in_max;
    logic [RW-1:0]       record_in;

    modport master (
        output capture_valid, capture_in, arm, force_trigger, post_count,
               trig_addr, trig_mask, dump_end, record_in_enable, record_in_request,
        input  armed, triggered, done, dump_start, record_in_max, record_in
    );

    modport slave (
        input  capture_valid, capture_in, arm, force_trigger, post_count,
               trig_addr, trig_mask, dump_end, record_in_enable, record_in_request,
        output armed, triggered, done, dump_start, record_in_max, record_in
    );
endinterface

// File: rtl/computie_bus_trace_controller.sv
// rtl/computie_bus_trace_controller.sv - circular bus-cycle trace capture with oldest-first dump serving
// Optional address-match trigger enabled by defining COMPUTIE_BUS_TRACE_ADDR_TRIGGER_EN.
module computie_bus_trace_controller #(
    parameter int BITWIDTH = 32,
    parameter int MODWIDTH = 1,
    parameter int DEPTH    = 512
) (
    input  logic                  comm_clock,
    input  logic                  comm_reset,
    computie_bus_trace_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = AW + 1;
    localparam int RW = 2 * BITWIDTH + MODWIDTH;
    localparam logic [IW-1:0] DEPTH_I = IW'(DEPTH);
    localparam logic [IW-1:0] LAST_I  = IW'(DEPTH - 1);
    localparam logic [IW-1:0] ONE_I   = IW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_POST,
        S_DUMP,
        S_WAIT
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] wr_ptr;
    logic [IW-1:0] count;
    logic [IW-1:0] remaining;
    logic [IW-1:0] post_len;
    logic          done_q;
    logic          done_next;
    logic          clear;
    logic          write;
    logic          trigger;
    logic          addr_hit;
    logic [AW-1:0] oldest;
    logic [AW-1:0] rd_addr;
    logic [RW-1:0] rd_data;
    logic [RW-1:0] mem [DEPTH];
    logic          unused_inputs;

`ifdef COMPUTIE_BUS_TRACE_ADDR_TRIGGER_EN
    assign addr_hit = bus.capture_valid &&
        (((bus.capture_in[2*BITWIDTH-1:BITWIDTH] ^ bus.trig_addr) & bus.trig_mask) == '0);
    assign unused_inputs = ^{bus.record_in_enable, bus.record_in_request[IW-1]};
`else
    assign addr_hit = 1'b0;
    assign unused_inputs = ^{bus.record_in_enable, bus.record_in_request[IW-1],
                             bus.trig_addr, bus.trig_mask};
`endif

    assign trigger = bus.force_trigger | addr_hit;

    // arm has priority over trigger and capture in every capture state; DUMP/WAIT ignore it
    always_comb begin
        state_next = state;
        clear      = 1'b0;
        write      = 1'b0;
        done_next  = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.arm) begin
                    clear      = 1'b1;
                    state_next = S_ARMED;
                end
            end
            S_ARMED: begin
                if (bus.arm) begin
                    clear = 1'b1;
                end else begin
                    write = bus.capture_valid;
                    if (trigger) state_next = (post_len == '0) ? S_DUMP : S_POST;
                end
            end
            S_POST: begin
                if (bus.arm) begin
                    clear      = 1'b1;
                    state_next = S_ARMED;
                end else if (bus.capture_valid) begin
                    write = 1'b1;
                    if (remaining == ONE_I) state_next = S_DUMP;
                end
            end
            S_DUMP: begin
                if (count == '0) begin
                    done_next  = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.dump_end) begin
                    done_next  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge comm_clock) begin
        if (comm_reset) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            count     <= '0;
            remaining <= '0;
            post_len  <= '0;
            done_q    <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= done_next;
            if (clear) begin
                wr_ptr   <= '0;
                count    <= '0;
                post_len <= (bus.post_count > LAST_I) ? LAST_I : bus.post_count;
            end else if (write) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (count != DEPTH_I) count <= count + ONE_I;
            end
            if (state == S_ARMED && state_next == S_POST) begin
                remaining <= post_len;
            end else if (state == S_POST && write) begin
                remaining <= remaining - ONE_I;
            end
        end
    end

    // Once the buffer has wrapped, the slot about to be overwritten holds the oldest record
    assign oldest  = (count == DEPTH_I) ? wr_ptr : '0;
    assign rd_addr = oldest + bus.record_in_request[AW-1:0];

    always_ff @(posedge comm_clock) begin
        if (write) mem[wr_ptr] <= bus.capture_in;
        rd_data <= mem[rd_addr];
    end

    assign bus.armed         = (state == S_ARMED);
    assign bus.triggered     = (state == S_POST) || (state == S_DUMP) || (state == S_WAIT);
    assign bus.dump_start    = (state == S_DUMP) && (count != '0);
    assign bus.done          = done_q;
    assign bus.record_in_max = (count == '0) ? '0 : count - ONE_I;
    assign bus.record_in     = rd_data;
endmodule

// File: tb/tb_computie_bus_trace_controller.sv
// tb/tb_computie_bus_trace_controller.sv - randomized self-checking bench against a queue model of the trace buffer
module tb_computie_bus_trace_controller;
    localparam int BITWIDTH = 32;
    localparam int MODWIDTH = 1;
    localparam int DEPTH    = 512;
    localparam int IW       = $clog2(DEPTH) + 1;
    localparam int RW       = 2 * BITWIDTH + MODWIDTH;

    logic comm_clock = 1'b0;
    logic comm_reset = 1'b1;

    computie_bus_trace_if #(.BITWIDTH(BITWIDTH), .MODWIDTH(MODWIDTH), .DEPTH(DEPTH)) bus ();

    computie_bus_trace_controller #(.BITWIDTH(BITWIDTH), .MODWIDTH(MODWIDTH), .DEPTH(DEPTH)) dut (
        .comm_clock (comm_clock),
        .comm_reset (comm_reset),
        .bus        (bus)
    );

    always #5 comm_clock = ~comm_clock;

    int vectors     = 0;
    int miscompares = 0;
    logic [RW-1:0] model [$];

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge comm_clock);
        #1;
    endtask

    function automatic logic [RW-1:0] rand_rec();
        return {1'($urandom), 32'($urandom) | 32'h1, 32'($urandom)};
    endfunction

    task automatic capture(input logic [RW-1:0] r, input logic trig);
        bus.capture_valid = 1'b1;
        bus.capture_in    = r;
        bus.force_trigger = trig;
        step();
        bus.capture_valid = 1'b0;
        bus.force_trigger = 1'b0;
        model.push_back(r);
        if (model.size() > DEPTH) model.delete(0);
    endtask

    task automatic gap();
        bus.capture_valid = 1'b0;
        bus.capture_in    = rand_rec();
        repeat ($urandom_range(0, 2)) step();
    endtask

    task automatic do_arm(input int post, input logic with_trig);
        bus.arm           = 1'b1;
        bus.post_count    = IW'(post);
        bus.force_trigger = with_trig;
        step();
        bus.arm           = 1'b0;
        bus.force_trigger = 1'b0;
        model.delete();
    endtask

    // Called on the cycle the controller is expected to be in DUMP
    task automatic finish_dump();
        int n;
        int k;
        n = model.size();
        chk("dump_start", bus.dump_start, n != 0);
        chk("armed_in_dump", bus.armed, 1'b0);
        if (n == 0) begin
            step();
            chk("done_skip", bus.done, 1'b1);
            step();
            chk("done_skip_clr", bus.done, 1'b0);
            return;
        end
        chk("record_in_max", bus.record_in_max, n - 1);
        step();
        chk("dump_start_pulse", bus.dump_start, 1'b0);
        for (int i = 0; i < n; i++) begin
            bus.record_in_request = IW'(i);
            step();
            chk($sformatf("sweep_idx%0d", i), bus.record_in, model[i]);
        end
        repeat (4) begin
            k = $urandom_range(0, n - 1);
            bus.record_in_request = IW'(k);
            step();
            chk($sformatf("rand_idx%0d", k), bus.record_in, model[k]);
        end
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0;
        chk("arm_ignored_in_dump", bus.armed, 1'b0);
        chk("done_wait", bus.done, 1'b0);
        bus.dump_end = 1'b1;
        step();
        bus.dump_end = 1'b0;
        chk("done", bus.done, 1'b1);
        chk("triggered_clr", bus.triggered, 1'b0);
        step();
        chk("done_pulse", bus.done, 1'b0);
    endtask

    task automatic run_trace(input int n_pre, input int post);
        int p;
        p = (post > DEPTH - 1) ? DEPTH - 1 : post;
        do_arm(post, 1'b0);
        chk("armed", bus.armed, 1'b1);
        for (int i = 0; i < n_pre; i++) begin
            gap();
            capture(rand_rec(), 1'b0);
        end
        chk("pre_not_triggered", bus.triggered, 1'b0);
        capture(rand_rec(), 1'b1);
        for (int i = 0; i < p; i++) begin
            if (i == 0) begin
                chk("post_triggered", bus.triggered, 1'b1);
                chk("post_no_start", bus.dump_start, 1'b0);
            end
            gap();
            capture(rand_rec(), 1'($urandom));
        end
        finish_dump();
    endtask

    initial begin
        bus.capture_valid     = 1'b0;
        bus.capture_in        = '0;
        bus.arm               = 1'b0;
        bus.force_trigger     = 1'b0;
        bus.post_count        = '0;
        bus.trig_addr         = '0;
        bus.trig_mask         = '1;
        bus.dump_end          = 1'b0;
        bus.record_in_enable  = 1'b0;
        bus.record_in_request = '0;

        repeat (3) step();
        comm_reset = 1'b0;
        chk("rst_armed", bus.armed, 1'b0);
        chk("rst_triggered", bus.triggered, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_dump_start", bus.dump_start, 1'b0);
        chk("rst_max", bus.record_in_max, '0);

        // A0..A4, triggering record, two post records -> eight entries
        run_trace(5, 2);

        // arm with force_trigger in IDLE: arm wins; then re-arm from ARMED clears the buffer
        do_arm(3, 1'b1);
        chk("arm_trig_armed", bus.armed, 1'b1);
        chk("arm_trig_not_triggered", bus.triggered, 1'b0);
        repeat (4) capture(rand_rec(), 1'b0);
        run_trace(2, 1);

        // trigger with nothing captured -> dump skipped
        do_arm(0, 1'b0);
        bus.force_trigger = 1'b1;
        step();
        bus.force_trigger = 1'b0;
        finish_dump();

        // arm during POST restarts capture
        do_arm(4, 1'b0);
        capture(rand_rec(), 1'b1);
        chk("post_before_rearm", bus.triggered, 1'b1);
        capture(rand_rec(), 1'b0);
        do_arm(1, 1'b0);
        chk("rearm_armed", bus.armed, 1'b1);
        chk("rearm_not_triggered", bus.triggered, 1'b0);
        capture(rand_rec(), 1'b1);
        capture(rand_rec(), 1'b0);
        finish_dump();

        // address trigger window
        do_arm(0, 1'b0);
        bus.trig_addr = 32'h0000_1000;
        bus.trig_mask = 32'hFFFF_F000;
        capture({1'b0, 32'h0000_0FFC, 32'($urandom)}, 1'b0);
        chk("addr_miss_armed", bus.armed, 1'b1);
        capture({1'b1, 32'h0000_1004, 32'($urandom)}, 1'b0);
`ifdef COMPUTIE_BUS_TRACE_ADDR_TRIGGER_EN
        chk("addr_hit_dump", bus.dump_start, 1'b1);
`else
        chk("addr_off_armed", bus.armed, 1'b1);
        chk("addr_off_no_start", bus.dump_start, 1'b0);
        capture(rand_rec(), 1'b1);
`endif
        bus.trig_addr = '0;
        bus.trig_mask = '1;
        finish_dump();

        // reset in the middle of a dump
        do_arm(0, 1'b0);
        repeat (3) capture(rand_rec(), 1'b0);
        capture(rand_rec(), 1'b1);
        chk("pre_reset_start", bus.dump_start, 1'b1);
        step();
        comm_reset = 1'b1;
        step();
        comm_reset = 1'b0;
        chk("mid_rst_armed", bus.armed, 1'b0);
        chk("mid_rst_triggered", bus.triggered, 1'b0);
        chk("mid_rst_dump_start", bus.dump_start, 1'b0);
        chk("mid_rst_max", bus.record_in_max, '0);
        do_arm(1, 1'b0);
        chk("post_rst_armed", bus.armed, 1'b1);
        capture(rand_rec(), 1'b1);
        capture(rand_rec(), 1'b0);
        finish_dump();

        // randomized traces
        repeat (3) run_trace($urandom_range(0, 40), $urandom_range(0, 6));

        // wrap: oldest kept is the 11th record, newest is the trigger record
        run_trace(DEPTH + 9, 0);

        // post_count above DEPTH-1 is clamped
        run_trace(3, DEPTH + 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
